// File: rtl/exec_pkg.sv
// exec_controller shared types and default widths.
// Run-sequencer FSM states live here.
package exec_pkg;

  localparam int EXEC_I  = 32;
  localparam int EXEC_N  = 8;
  localparam int EXEC_R  = 6;
  localparam int EXEC_CW = 24;

  typedef enum logic [2:0] {
    IDLE,
    CPURST,
    START,
    RUN,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/exec_controller_mem_arbiter.sv
// Data-memory mux between host and CPU.
// Host side is a 2-cycle req/ack access.
module mem_arbiter
  import exec_pkg::*;
#(
  parameter int I = EXEC_I,
  parameter int W = EXEC_N * EXEC_R
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         own_cpu,
  input  logic         host_en,
  input  logic         host_req,
  input  logic         host_we,
  input  logic [I-1:0] host_addr,
  input  logic [W-1:0] host_wdata,
  output logic         host_ack,
  output logic [W-1:0] host_rdata,
  input  logic [I-1:0] cpu_addr,
  input  logic [W-1:0] cpu_wdata,
  input  logic         cpu_we,
  output logic [I-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [W-1:0] mem_rdata,
  output logic         issue
);

  logic ack_q;

  // a held request re-issues only once ack has dropped
  assign issue = host_en & ~own_cpu & host_req
               & ~ack_q & ~reset;

  assign host_ack   = ack_q;
  assign host_rdata = mem_rdata;

  // select the memory owner; the other side never writes
  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = issue & host_we;
    if (own_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we & ~reset;
    end
  end

  // ack lands one cycle after issue, with read data
  always_ff @(posedge clk) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= issue;
  end

endmodule

// File: rtl/exec_controller.sv
// Run sequencer for the vector CPU plus
// data-memory arbitration with the host.
module exec_controller
  import exec_pkg::*;
#(
  parameter int I  = EXEC_I,
  parameter int N  = EXEC_N,
  parameter int R  = EXEC_R,
  parameter int CW = EXEC_CW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           host_run,
  input  logic           host_clear,
  input  logic [CW-1:0]  max_cycles,
  input  logic           host_req,
  input  logic           host_we,
  input  logic [I-1:0]   host_addr,
  input  logic [R*N-1:0] host_wdata,
  output logic           host_ack,
  output logic [R*N-1:0] host_rdata,
  output logic           cpu_reset,
  output logic           cpu_start,
  input  logic           cpu_end,
  input  logic [I-1:0]   cpu_addr,
  input  logic [R*N-1:0] cpu_wdata,
  input  logic           cpu_we,
  output logic [I-1:0]   mem_addr,
  output logic [R*N-1:0] mem_wdata,
  output logic           mem_we,
  input  logic [R*N-1:0] mem_rdata,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [CW-1:0]  cycle_count
);

  state_t state;
  logic   own_cpu;
  logic   run_pend;
  logic   issue;
  logic   run_req;

  assign run_req = host_run | run_pend;

  mem_arbiter #(
    .I (I),
    .W (R * N)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .own_cpu    (own_cpu),
    .host_en    (~busy),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .issue      (issue)
  );

  // sequencer; outputs registered with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_reset   <= 1'b1;
      cpu_start   <= 1'b0;
      busy        <= 1'b0;
      own_cpu     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      run_pend    <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      if (host_clear) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
      unique case (state)
        IDLE, DONE: begin
          if (run_req) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            // let a host access just issued get its ack first
            if (issue) begin
              run_pend <= 1'b1;
            end else begin
              run_pend  <= 1'b0;
              state     <= CPURST;
              cpu_reset <= 1'b1;
              busy      <= 1'b1;
            end
          end else if (state == DONE && host_clear) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
          end
        end
        CPURST: begin
          state     <= START;
          cpu_reset <= 1'b0;
          cpu_start <= 1'b1;
          own_cpu   <= 1'b1;
        end
        START: begin
          state       <= RUN;
          cycle_count <= '0;
        end
        RUN: begin
          if (cycle_count != '1)
            cycle_count <= cycle_count + CW'(1);
          if (cpu_end) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            own_cpu <= 1'b0;
          end else if (max_cycles != '0 &&
                       cycle_count == max_cycles - CW'(1)) begin
            state     <= ABORT;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            own_cpu   <= 1'b0;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller.
// Random runs checked against an outcome model.
module tb_exec_controller;

  localparam int I  = 32;
  localparam int N  = 8;
  localparam int R  = 6;
  localparam int CW = 24;
  localparam int W  = R * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_run, host_clear;
  logic [CW-1:0] max_cycles;
  logic          host_req, host_we;
  logic [I-1:0]  host_addr;
  logic [W-1:0]  host_wdata;
  logic          host_ack;
  logic [W-1:0]  host_rdata;
  logic          cpu_reset, cpu_start, cpu_end;
  logic [I-1:0]  cpu_addr;
  logic [W-1:0]  cpu_wdata;
  logic          cpu_we;
  logic [I-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic          mem_we;
  logic [W-1:0]  mem_rdata;
  logic          busy, done, timeout;
  logic [CW-1:0] cycle_count;

  exec_controller #(.I(I), .N(N), .R(R), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .host_run(host_run), .host_clear(host_clear),
    .max_cycles(max_cycles),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start),
    .cpu_end(cpu_end), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // behavioural data memory, 1-cycle read
  logic [W-1:0] mem     [16];
  logic [W-1:0] exp_mem [16];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[3:0]];
  end

  int nvec = 0;
  int nerr = 0;
  int we_cnt = 0, busy_cnt = 0;
  int start_cnt = 0, ack_busy = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (cpu_start === 1'b1) start_cnt++;
    if (host_ack === 1'b1 && busy === 1'b1) ack_busy++;
  end

  int           wr_k = 0;
  logic [3:0]   wr_a = '0;
  logic [W-1:0] wr_d = '0;
  logic         hold_req = 1'b0;
  logic [3:0]   rd_a = '0;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_xfer(input logic we, input logic [3:0] a,
                           input logic [W-1:0] d,
                           output logic [W-1:0] rd, output int lat);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = {28'b0, a};
    host_wdata = d;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (host_ack !== 1'b1 && lat < 20);
    rd = host_rdata;
    host_req = 1'b0;
    host_we  = 1'b0;
    tick;
  endtask

  // drives one run from IDLE/DONE; returns observations only
  task automatic do_run(input int d, input logic [CW-1:0] mc,
                        output logic rst_ok, output logic st_ok,
                        output int runs);
    int n;
    int k;
    max_cycles = mc;
    host_run = 1'b1;
    tick;
    host_run = 1'b0;
    rst_ok = (busy === 1'b1 && cpu_reset === 1'b1 &&
              cpu_start === 1'b0);
    n = 0;
    while (cpu_start !== 1'b1 && n < 8) begin
      tick;
      n++;
    end
    st_ok = (cpu_start === 1'b1 && cpu_reset === 1'b0 && n == 1);
    if (hold_req) begin
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = {28'b0, rd_a};
    end
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      tick;
      k++;
      cpu_end   = (k == d);
      cpu_we    = (k == wr_k);
      cpu_addr  = {28'b0, wr_a};
      cpu_wdata = wr_d;
    end
    cpu_end = 1'b0;
    cpu_we  = 1'b0;
    runs = k - 1;
  endtask

  task test_reset;
    reset = 1'b1;
    host_run = 0; host_clear = 0; max_cycles = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    cpu_end = 0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    repeat (3) tick;
    nvec++;
    if ({cpu_reset, cpu_start, host_ack, mem_we,
         busy, done, timeout} !== 7'b1000000) begin
      nerr++;
      $display("FAIL reset_flags got %b want 1000000",
               {cpu_reset, cpu_start, host_ack, mem_we,
                busy, done, timeout});
    end
    nvec++;
    if (cycle_count !== '0) begin
      nerr++;
      $display("FAIL reset_count got %0d want 0", cycle_count);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_host_access;
    logic [W-1:0] d, rd;
    logic [3:0]   a;
    logic         we;
    int lat, w0;
    d = {8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    w0 = we_cnt;
    host_xfer(1'b1, 4'd4, d, rd, lat);
    exp_mem[4] = d;
    nvec++;
    if (lat !== 1) begin
      nerr++;
      $display("FAIL wr_latency got %0d want 1", lat);
    end
    nvec++;
    if (we_cnt - w0 !== 1) begin
      nerr++;
      $display("FAIL wr_we_cycles got %0d want 1", we_cnt - w0);
    end
    w0 = we_cnt;
    host_xfer(1'b0, 4'd4, '0, rd, lat);
    nvec++;
    if (rd !== d || lat !== 1) begin
      nerr++;
      $display("FAIL rd_addr4 got %h/%0d want %h/1", rd, lat, d);
    end
    nvec++;
    if (we_cnt !== w0) begin
      nerr++;
      $display("FAIL rd_no_we got %0d want 0", we_cnt - w0);
    end
    repeat (16) begin
      a  = 4'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      d  = W'({$urandom(), $urandom()});
      host_xfer(we, a, d, rd, lat);
      if (we) begin
        exp_mem[a] = d;
      end else begin
        nvec++;
        if (rd !== exp_mem[a] || lat !== 1) begin
          nerr++;
          $display("FAIL rand_rd a=%0d got %h/%0d want %h/1",
                   a, rd, lat, exp_mem[a]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    logic [W-1:0] x;
    acks = 0;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 32'd4;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (host_ack === 1'b1) begin
        acks++;
        nvec++;
        if (host_rdata !== exp_mem[4]) begin
          nerr++;
          $display("FAIL b2b_data got %h want %h",
                   host_rdata, exp_mem[4]);
        end
      end
    end
    host_req = 1'b0;
    tick;
    nvec++;
    if (acks !== 4) begin
      nerr++;
      $display("FAIL b2b_rate got %0d want 4", acks);
    end
    // run arriving with an access in flight waits for its ack
    x = W'({$urandom(), $urandom()});
    max_cycles = '0;
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 32'd5; host_wdata = x;
    host_run = 1'b1;
    tick;
    host_run = 1'b0;
    exp_mem[5] = x;
    nvec++;
    if (host_ack !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL pend_ack got ack=%b busy=%b want 1/0",
               host_ack, busy);
    end
    host_req = 1'b0; host_we = 1'b0;
    tick;
    nvec++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
      nerr++;
      $display("FAIL pend_cpurst got busy=%b rst=%b want 1/1",
               busy, cpu_reset);
    end
    cpu_end = 1'b1;
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick;
    cpu_end = 1'b0;
    nvec++;
    if (done !== 1'b1 || cycle_count !== 24'd1) begin
      nerr++;
      $display("FAIL pend_run got done=%b cnt=%0d want 1/1",
               done, cycle_count);
    end
    host_clear = 1'b1;
    tick;
    host_clear = 1'b0;
  endtask

  // expected outcome from the run rules, not the FSM
  task automatic check_run(input string nm, input int d,
                           input logic [CW-1:0] mc);
    logic rst_ok, st_ok;
    int runs, b0, s0, ecnt;
    logic eab;
    eab  = (mc != 0) && (d == 0 || int'(mc) < d);
    ecnt = eab ? int'(mc) : d;
    b0 = busy_cnt;
    s0 = start_cnt;
    do_run(d, mc, rst_ok, st_ok, runs);
    nvec++;
    if (rst_ok !== 1'b1 || st_ok !== 1'b1) begin
      nerr++;
      $display("FAIL %s_seq got rst=%b start=%b want 1/1",
               nm, rst_ok, st_ok);
    end
    nvec++;
    if (runs !== ecnt || busy_cnt - b0 !== ecnt + 2 ||
        start_cnt - s0 !== 1) begin
      nerr++;
      $display("FAIL %s_len got run=%0d busy=%0d st=%0d want %0d/%0d/1",
               nm, runs, busy_cnt - b0, start_cnt - s0,
               ecnt, ecnt + 2);
    end
    nvec++;
    if (done !== !eab || timeout !== eab ||
        cycle_count !== CW'(ecnt) || cpu_reset !== eab) begin
      nerr++;
      $display("FAIL %s_end got d=%b t=%b c=%0d r=%b want %b/%b/%0d/%b",
               nm, done, timeout, cycle_count, cpu_reset,
               !eab, eab, ecnt, eab);
    end
    if (eab) begin
      tick;
      nvec++;
      if (done !== 1'b0 || cpu_reset !== 1'b1 || timeout !== 1'b1) begin
        nerr++;
        $display("FAIL %s_idle got d=%b r=%b t=%b want 0/1/1",
                 nm, done, cpu_reset, timeout);
      end
    end
    host_clear = 1'b1;
    tick;
    host_clear = 1'b0;
    nvec++;
    if (done !== 1'b0 || timeout !== 1'b0 || cpu_reset !== 1'b1) begin
      nerr++;
      $display("FAIL %s_clear got d=%b t=%b r=%b want 0/0/1",
               nm, done, timeout, cpu_reset);
    end
  endtask

  task test_run_done;
    check_run("run10", 10, '0);
  endtask

  task test_watchdog;
    check_run("wdog5", 0, 24'd5);
  endtask

  task test_priority;
    check_run("prio7", 7, 24'd7);
  endtask

  task automatic test_random_runs;
    int d, sel;
    logic [CW-1:0] mc;
    repeat (6) begin
      d   = $urandom_range(1, 25);
      sel = $urandom_range(0, 2);
      case (sel)
        0:       mc = '0;
        1:       mc = CW'($urandom_range(1, 25));
        default: mc = CW'(d);
      endcase
      check_run("rand", d, mc);
    end
  endtask

  task automatic test_stall;
    logic rst_ok, st_ok;
    int runs, w0, a0;
    wr_k = 3; wr_a = 4'd8;
    wr_d = W'({$urandom(), $urandom()});
    rd_a = 4'd8;
    hold_req = 1'b1;
    w0 = we_cnt;
    a0 = ack_busy;
    do_run(6, '0, rst_ok, st_ok, runs);
    exp_mem[8] = wr_d;
    nvec++;
    if (we_cnt - w0 !== 1 || ack_busy !== a0) begin
      nerr++;
      $display("FAIL stall_run got we=%0d ackbusy=%0d want 1/0",
               we_cnt - w0, ack_busy - a0);
    end
    nvec++;
    if (done !== 1'b1 || host_ack !== 1'b0) begin
      nerr++;
      $display("FAIL stall_done got d=%b ack=%b want 1/0",
               done, host_ack);
    end
    tick;
    nvec++;
    if (host_ack !== 1'b1 || host_rdata !== exp_mem[8]) begin
      nerr++;
      $display("FAIL stall_ack got ack=%b %h want 1 %h",
               host_ack, host_rdata, exp_mem[8]);
    end
    host_req = 1'b0;
    hold_req = 1'b0;
    wr_k = 0;
    host_clear = 1'b1;
    tick;
    host_clear = 1'b0;
  endtask

  task automatic test_reset_midrun;
    logic rst_ok, st_ok;
    int runs;
    max_cycles = '0;
    host_run = 1'b1;
    tick;
    host_run = 1'b0;
    repeat ($urandom_range(4, 12)) tick;
    reset = 1'b1;
    tick;
    nvec++;
    if ({cpu_reset, cpu_start, host_ack, mem_we,
         busy, done, timeout} !== 7'b1000000 ||
        cycle_count !== '0) begin
      nerr++;
      $display("FAIL midrst got %b c=%0d want 1000000 c=0",
               {cpu_reset, cpu_start, host_ack, mem_we,
                busy, done, timeout}, cycle_count);
    end
    reset = 1'b0;
    tick;
    do_run(3, '0, rst_ok, st_ok, runs);
    nvec++;
    if (done !== 1'b1 || cycle_count !== 24'd3) begin
      nerr++;
      $display("FAIL midrst_run got d=%b c=%0d want 1/3",
               done, cycle_count);
    end
    host_run = 1'b1;
    host_clear = 1'b1;
    tick;
    host_run = 1'b0;
    host_clear = 1'b0;
    nvec++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL runclr got b=%b r=%b d=%b want 1/1/0",
               busy, cpu_reset, done);
    end
    cpu_end = 1'b1;
    for (int i = 0; i < 10 && busy === 1'b1; i++) tick;
    cpu_end = 1'b0;
    nvec++;
    if (done !== 1'b1 || cycle_count !== 24'd1) begin
      nerr++;
      $display("FAIL runclr_end got d=%b c=%0d want 1/1",
               done, cycle_count);
    end
    host_clear = 1'b1;
    tick;
    host_clear = 1'b0;
  endtask

  task automatic test_mem_final;
    logic [W-1:0] rd;
    int lat;
    for (int i = 0; i < 16; i++) begin
      host_xfer(1'b0, 4'(i), '0, rd, lat);
      nvec++;
      if (rd !== exp_mem[i]) begin
        nerr++;
        $display("FAIL final_rd a=%0d got %h want %h",
                 i, rd, exp_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_host_access;
    test_back_to_back;
    test_run_done;
    test_watchdog;
    test_stall;
    test_priority;
    test_random_runs;
    test_reset_midrun;
    test_mem_final;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run-sequencing controller and data-memory arbiter that sits between the host interface, the vector CPU (`cpu`) and the shared vector data memory.
- Accepts a run command, resets and starts the CPU, and counts execution cycles until EndFlag or a watchdog limit is reached.
- Gives the host exclusive data-memory access whenever the CPU is not running.

Parameters:
- I, 32, address width (matches CPU address/instruction width)
- N, 8, bits per vector lane
- R, 6, number of vector lanes
- CW, 24, cycle-counter / watchdog width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- host_run  in  1  one-cycle run command
- host_clear  in  1  clears done/timeout status
- max_cycles  in  CW  watchdog limit; 0 disables watchdog
- host_req  in  1  host memory request, held until host_ack
- host_we  in  1  host write enable (qualified by host_req)
- host_addr  in  I  host memory address
- host_wdata  in  R*N  host write data ([R-1:0][N-1:0])
- host_ack  out  1  one-cycle access acknowledge
- host_rdata  out  R*N  read data, valid while host_ack=1
- cpu_reset  out  1  reset to CPU
- cpu_start  out  1  start pulse to CPU
- cpu_end  in  1  CPU EndFlag
- cpu_addr  in  I  CPU AddressM
- cpu_wdata  in  R*N  CPU WriteDataM
- cpu_we  in  1  CPU MemWriteM
- mem_addr  out  I  memory address
- mem_wdata  out  R*N  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  R*N  memory read data (1-cycle synchronous read)
- busy  out  1  CPU sequence in progress
- done  out  1  sticky: run completed via cpu_end
- timeout  out  1  sticky: run aborted by watchdog
- cycle_count  out  CW  cycles spent in RUN for the last/current run

Behaviour:
- Reset values:
  - FSM=IDLE
  - cpu_reset=1
  - cpu_start=0, host_ack=0, mem_we=0
  - busy=0, done=0, timeout=0
  - cycle_count=0
- FSM states: IDLE, CPURST, START, RUN, DONE, ABORT.
- IDLE:
  - cpu_reset=1 (CPU held in reset).
  - host_run -> CPURST, and clears done/timeout.
- CPURST: cpu_reset=1 for exactly 1 cycle -> START.
- START:
  - cpu_reset=0, cpu_start=1 for exactly 1 cycle, cycle_count<=0 -> RUN.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones.
  - cpu_end=1 -> DONE; done<=1.
  - Else if max_cycles!=0 and cycle_count==max_cycles-1 -> ABORT.
  - cpu_end takes priority over the watchdog in the same cycle.
- ABORT: cpu_reset=1, timeout<=1 for 1 cycle -> IDLE.
- DONE:
  - cpu_reset=0 (CPU frozen at end).
  - host_run -> CPURST.
  - host_clear -> IDLE.
- busy=1 in CPURST, START and RUN.
- host_run while busy is ignored.
- host_clear clears done/timeout in any state.
- host_clear and host_run in the same cycle: host_run wins.
- Memory mux:
  - RUN, and the START cycle: mem_* driven by cpu_*.
  - All other states: driven by the host path.
  - mem_we is never asserted by an unselected source.
- Host handshake (host owns memory):
  - Cycle 0: host_req seen; mem_addr=host_addr, mem_we=host_req&host_we.
  - Cycle 1: host_ack=1 and host_rdata=mem_rdata.
  - At most one outstanding access. A held req is re-issued only after ack falls, giving 1 access per 2 cycles.
  - While busy, host_req is stalled: no ack, no mem_we.
  - A host access in flight when host_run arrives completes (ack is delivered) before CPURST is entered. The FSM waits in IDLE with the run pending.
- reset mid-run: immediate return to IDLE next edge, all outputs to reset values, and the pending host access is dropped.

Decomposition:
- Package exec_pkg: enum state_t {IDLE, CPURST, START, RUN, DONE, ABORT} and the default width constants.
- Sub-module mem_arbiter: combinational mux plus the host ack register, selected by an own_cpu signal from the FSM.

Test Plan:
1. Reset, then host writes 0x0A..0x0F lanes to addr 4 and reads addr 4 -> host_ack 1 cycle after each req; read returns same lanes; mem_we high exactly 1 cycle.
2. host_run with max_cycles=0; cpu_end asserted 10 cycles after cpu_start -> cpu_reset 1 cycle, then cpu_start 1 cycle; busy for 12 cycles; done=1; cycle_count=10; timeout=0.
3. host_run with max_cycles=5 and cpu_end never asserted -> ABORT after 5 RUN cycles; timeout=1; cpu_reset=1; back in IDLE with done=0.
4. host_req held during RUN; cpu_we writes addr 8 -> mem_we follows cpu_we only; no host_ack until DONE; host access then completes 1 cycle later.
5. cpu_end and the watchdog limit in the same cycle (max_cycles=7, end at count 6) -> DONE; done=1; timeout=0.
6. reset asserted mid-RUN, then host_run in the same cycle as host_clear in DONE -> reset values next edge; run restarts via CPURST with done cleared.
